adder_share_arbiter: RTL and testbench



---
 rtl/adder_share_arbiter_pkg.sv | 16 +
 rtl/Sklansky32Bit.sv | 45 ++++
 rtl/adder_share_arbiter_rr_arbiter.sv | 29 ++
 rtl/adder_share_arbiter.sv | 166 ++++++++++++++++
 tb/tb_adder_share_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/adder_share_arbiter_pkg.sv
// Shared state encodings, datapath width and overflow helper for adder_share_arbiter.
package adder_share_arbiter_pkg;

    localparam int unsigned ADW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EXEC   = 2'd1,
        ST_RESULT = 2'd2
    } state_e;

    function automatic logic signed_ovf(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/Sklansky32Bit.sv
// 32-bit Sklansky parallel-prefix adder with carry-in; testP/testG expose the bitwise P/G.
module Sklansky32Bit (
    input  logic [31:0] i_a,
    input  logic [31:0] i_b,
    input  logic        i_cin,
    output logic [31:0] o_sum,
    output logic        o_cout,
    output logic [31:0] testP,
    output logic [31:0] testG
);

    logic [5:0][31:0] w_g;
    logic [5:0][31:0] w_p;
    logic [32:0]      w_c;

    always_comb begin
        w_g    = '0;
        w_p    = '0;
        w_c    = '0;
        w_g[0] = i_a & i_b;
        w_p[0] = i_a ^ i_b;
        // Level l: bits with bit l set absorb the last bit of the preceding 2^l block.
        for (int l = 0; l < 5; l++) begin
            for (int i = 0; i < 32; i++) begin
                if (((i >> l) & 1) == 1) begin
                    w_g[l+1][i] = w_g[l][i] | (w_p[l][i] & w_g[l][((i >> l) << l) - 1]);
                    w_p[l+1][i] = w_p[l][i] & w_p[l][((i >> l) << l) - 1];
                end else begin
                    w_g[l+1][i] = w_g[l][i];
                    w_p[l+1][i] = w_p[l][i];
                end
            end
        end
        w_c[0] = i_cin;
        for (int i = 0; i < 32; i++) begin
            w_c[i+1] = w_g[5][i] | (w_p[5][i] & i_cin);
        end
    end

    assign o_sum  = w_p[0] ^ w_c[31:0];
    assign o_cout = w_c[32];
    assign testP  = w_p[0];
    assign testG  = w_g[0];

endmodule

// File: rtl/adder_share_arbiter_rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after i_ptr, modulo NREQ.
module rr_arbiter #(
    parameter  int unsigned NREQ = 4,
    localparam int unsigned PW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] i_req,
    input  logic [PW-1:0]   i_ptr,
    output logic [NREQ-1:0] o_grant,
    output logic [PW-1:0]   o_grant_idx,
    output logic            o_any
);

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        // Step k inspects requester (ptr + k) mod NREQ, i.e. i where ptr == (i - k) mod NREQ.
        for (int k = 0; k < NREQ; k++) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!o_any && i_req[i] && (i_ptr == PW'((i + NREQ - k) % NREQ))) begin
                    o_any       = 1'b1;
                    o_grant[i]  = 1'b1;
                    o_grant_idx = PW'(i);
                end
            end
        end
    end

endmodule

// File: rtl/adder_share_arbiter.sv
// Shares one Sklansky32Bit adder among NREQ valid/ready requesters (accept, compute, deliver).
// Define ADDER_ARB_STATS_EN to add the saturating stat_ops completed-op counter.
module adder_share_arbiter
    import adder_share_arbiter_pkg::*;
#(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IDW  = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NREQ-1:0]     req_valid,
    output logic [NREQ-1:0]     req_ready,
    input  logic [NREQ*ADW-1:0] req_a,
    input  logic [NREQ*ADW-1:0] req_b,
    input  logic [NREQ-1:0]     req_cin,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [ADW:0]        res_sum,
    output logic                res_ovf,
    output logic [IDW-1:0]      res_id
`ifdef ADDER_ARB_STATS_EN
    ,
    output logic [15:0]         stat_ops
`endif
);

    localparam int unsigned PW = $clog2(NREQ);

    state_e         r_state, w_state_next;
    logic [PW-1:0]  r_rr_ptr;
    logic [ADW-1:0] r_op_a, r_op_b;
    logic           r_op_cin;
    logic [PW-1:0]  r_op_id;
    logic           r_res_valid;
    logic [ADW:0]   r_res_sum;
    logic           r_res_ovf;
    logic [IDW-1:0] r_res_id;

    logic [NREQ-1:0] w_grant;
    logic [PW-1:0]   w_grant_idx;
    logic            w_any, w_accept, w_deliver;
    logic [ADW-1:0]  w_sel_a, w_sel_b;
    logic            w_sel_cin;
    logic [ADW-1:0]  w_sum;
    logic            w_cout;
    logic [ADW-1:0]  w_unused_p, w_unused_g;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr_arbiter (
        .i_req       (req_valid),
        .i_ptr       (r_rr_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_grant_idx),
        .o_any       (w_any)
    );

    Sklansky32Bit u_adder (
        .i_a    (r_op_a),
        .i_b    (r_op_b),
        .i_cin  (r_op_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .testP  (w_unused_p),
        .testG  (w_unused_g)
    );

    always_comb begin
        w_sel_a   = '0;
        w_sel_b   = '0;
        w_sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (w_grant[i]) begin
                w_sel_a   = req_a[i*ADW +: ADW];
                w_sel_b   = req_b[i*ADW +: ADW];
                w_sel_cin = req_cin[i];
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        req_ready    = '0;
        w_accept     = 1'b0;
        w_deliver    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                // Ready is masked while reset is asserted so nothing looks accepted.
                if (!rst) begin
                    req_ready = w_grant;
                    if (w_any) begin
                        w_accept     = 1'b1;
                        w_state_next = ST_EXEC;
                    end
                end
            end
            ST_EXEC: w_state_next = ST_RESULT;
            ST_RESULT: begin
                if (res_ready) begin
                    w_deliver    = 1'b1;
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rr_ptr    <= '0;
            r_op_a      <= '0;
            r_op_b      <= '0;
            r_op_cin    <= 1'b0;
            r_op_id     <= '0;
            r_res_valid <= 1'b0;
            r_res_sum   <= '0;
            r_res_ovf   <= 1'b0;
            r_res_id    <= '0;
        end else begin
            if (w_accept) begin
                r_op_a   <= w_sel_a;
                r_op_b   <= w_sel_b;
                r_op_cin <= w_sel_cin;
                r_op_id  <= w_grant_idx;
                r_rr_ptr <= (w_grant_idx == PW'(NREQ - 1)) ? '0 : w_grant_idx + 1'b1;
            end
            if (r_state == ST_EXEC) begin
                r_res_valid <= 1'b1;
                r_res_sum   <= {w_cout, w_sum};
                r_res_ovf   <= signed_ovf(r_op_a[ADW-1], r_op_b[ADW-1], w_sum[ADW-1]);
                r_res_id    <= IDW'(r_op_id);
            end
            if (w_deliver) begin
                r_res_valid <= 1'b0;
            end
        end
    end

    assign res_valid = r_res_valid;
    assign res_sum   = r_res_sum;
    assign res_ovf   = r_res_ovf;
    assign res_id    = r_res_id;

`ifdef ADDER_ARB_STATS_EN
    logic [15:0] r_stat_ops;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stat_ops <= '0;
        end else if (w_deliver && (r_stat_ops != 16'hFFFF)) begin
            r_stat_ops <= r_stat_ops + 16'd1;
        end
    end

    assign stat_ops = r_stat_ops;
`endif

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed bench for adder_share_arbiter; stat_ops checks compile in with ADDER_ARB_STATS_EN.
module tb_adder_share_arbiter;

    localparam int unsigned NREQ = 4;
    localparam int unsigned IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*32-1:0] req_a;
    logic [NREQ*32-1:0] req_b;
    logic [NREQ-1:0]   req_cin;
    logic              res_valid;
    logic              res_ready;
    logic [32:0]       res_sum;
    logic              res_ovf;
    logic [IDW-1:0]    res_id;
`ifdef ADDER_ARB_STATS_EN
    logic [15:0]       stat_ops;
`endif

    int checks   = 0;
    int failures = 0;

    logic [3:0]  exp_rdy;
    logic [32:0] rr_sum [4] = '{33'h0_1000_0005, 33'h0_2000_0007, 33'h0_3000_0007,
                                33'h0_4000_0009};

    adder_share_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_ovf   (res_ovf),
        .res_id    (res_id)
`ifdef ADDER_ARB_STATS_EN
        ,
        .stat_ops  (stat_ops)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                          input logic c);
        req_a[i*32 +: 32] = a;
        req_b[i*32 +: 32] = b;
        req_cin[i]        = c;
    endtask

    initial begin
        rst       = 1'b1;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        res_ready = 1'b0;
        tick();
        tick();
        check("reset_valid", 64'(res_valid), 64'h0);
        check("reset_ready", 64'(req_ready), 64'h0);
        check("reset_sum", 64'(res_sum), 64'h0);
        check("reset_ovf", 64'(res_ovf), 64'h0);
        check("reset_id", 64'(res_id), 64'h0);
`ifdef ADDER_ARB_STATS_EN
        check("reset_stat", 64'(stat_ops), 64'h0);
`endif
        rst = 1'b0;
        #1;

        // Single request from requester 1, both operands negative -> signed overflow.
        set_op(1, 32'h96C6_B9EE, 32'h94F6_B96A, 1'b0);
        req_valid = 4'b0010;
        #1;
        check("t1_ready", 64'(req_ready), 64'h2);
        tick();
        req_valid = '0;
        check("t1_exec_valid", 64'(res_valid), 64'h0);
        check("t1_exec_ready", 64'(req_ready), 64'h0);
        tick();
        check("t1_valid", 64'(res_valid), 64'h1);
        check("t1_sum", 64'(res_sum), 64'h1_2BBD_7358);
        check("t1_ovf", 64'(res_ovf), 64'h1);
        check("t1_id", 64'(res_id), 64'h1);
        res_ready = 1'b1;
        tick();
        check("t1_done", 64'(res_valid), 64'h0);

        // Carry wrap from requester 0; pointer is at 2 so the search wraps around.
        set_op(0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        req_valid = 4'b0001;
        #1;
        check("t2_ready", 64'(req_ready), 64'h1);
        tick();
        req_valid = '0;
        tick();
        check("t2_sum", 64'(res_sum), 64'h1_0000_0000);
        check("t2_ovf", 64'(res_ovf), 64'h0);
        check("t2_id", 64'(res_id), 64'h0);
        tick();

        // Asynchronous reset while requester 2's op is executing.
        set_op(2, 32'h1, 32'h2, 1'b0);
        req_valid = 4'b0100;
        #1;
        check("t3_ready", 64'(req_ready), 64'h4);
        tick();
        req_valid = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            set_op(i, 32'h1000_0000 * (i + 1), 32'(i + 5), 1'(i & 1));
        end
        #2;
        rst = 1'b1;
        #1;
        check("rst_valid", 64'(res_valid), 64'h0);
        check("rst_ready", 64'(req_ready), 64'h0);
        tick();
        check("rst_hold_valid", 64'(res_valid), 64'h0);
        rst = 1'b0;
        #1;
        check("rst_grant0", 64'(req_ready), 64'h1);

        // Round-robin with all four requesters continuously valid.
        for (int k = 0; k < 5; k++) begin
            exp_rdy = 4'(1 << (k % 4));
            check("rr_ready", 64'(req_ready), 64'(exp_rdy));
            tick();
            tick();
            check("rr_valid", 64'(res_valid), 64'h1);
            check("rr_id", 64'(res_id), 64'(k % 4));
            check("rr_sum", 64'(res_sum), 64'(rr_sum[k % 4]));
            tick();
`ifdef ADDER_ARB_STATS_EN
            if (k == 2) check("stat_three", 64'(stat_ops), 64'h3);
`endif
        end

        // Backpressure: result must hold while res_ready is low.
        res_ready = 1'b0;
        check("bp_grant", 64'(req_ready), 64'h2);
        tick();
        tick();
        check("bp_valid", 64'(res_valid), 64'h1);
        check("bp_sum", 64'(res_sum), 64'h0_2000_0007);
        check("bp_id", 64'(res_id), 64'h1);
        for (int n = 0; n < 5; n++) begin
            tick();
            check("bp_hold_valid", 64'(res_valid), 64'h1);
            check("bp_hold_sum", 64'(res_sum), 64'h0_2000_0007);
            check("bp_hold_id", 64'(res_id), 64'h1);
            check("bp_hold_ready", 64'(req_ready), 64'h0);
        end
        res_ready = 1'b1;
        tick();
        check("bp_release_valid", 64'(res_valid), 64'h0);
        check("bp_next_grant", 64'(req_ready), 64'h4);

        // Idle with no requests keeps the pointer at 2, so {0,1,3} valid grants 3.
        req_valid = '0;
        tick();
        tick();
        tick();
        check("idle_ready", 64'(req_ready), 64'h0);
        check("idle_valid", 64'(res_valid), 64'h0);
        req_valid = 4'b1011;
        #1;
        check("idle_ptr_grant", 64'(req_ready), 64'h8);
        tick();
        req_valid = '0;
        tick();
        check("last_sum", 64'(res_sum), 64'h0_4000_0009);
        check("last_id", 64'(res_id), 64'h3);
`ifdef ADDER_ARB_STATS_EN
        force dut.r_stat_ops = 16'hFFFF;
        #1;
        release dut.r_stat_ops;
`endif
        tick();
        check("last_done", 64'(res_valid), 64'h0);
`ifdef ADDER_ARB_STATS_EN
        check("stat_saturate", 64'(stat_ops), 64'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
